// File: rtl/taylor_trig_unit.sv
// Sin/cos via a truncated Taylor series: one FSM driving a single shared fixed-point multiplier.
// The operand and mode are captured on start; result holds until the next completed operation.
module taylor_trig_unit #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 13,
  parameter int N_TERMS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] x_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int ONE = 1 << FRAC_W;
  localparam logic [DATA_W-1:0] OneV   = DATA_W'(ONE);
  localparam logic [DATA_W-1:0] SatMax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SatMin = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StSquare,
    StMulX2,
    StMulC,
    StAcc,
    StFinish
  } state_t;

  // round(ONE / d) with the per-mode series denominator for index k
  function automatic int coef_val(input int m, input int k);
    int d;
    d = (m != 0) ? (2 * k + 1) * (2 * k + 2) : (2 * k + 2) * (2 * k + 3);
    return (2 * ONE + d) / (2 * d);
  endfunction

  logic [DATA_W-1:0] coef_sin [8];
  logic [DATA_W-1:0] coef_cos [8];

  for (genvar g = 0; g < 8; g++) begin : g_coef
    assign coef_sin[g] = DATA_W'(coef_val(0, g));
    assign coef_cos[g] = DATA_W'(coef_val(1, g));
  end

  state_t            state_q;
  logic [DATA_W-1:0] x_q, x2_q, term_q, acc_q;
  logic [2:0]        k_q;
  logic              mode_q;

  logic [DATA_W-1:0]   mul_a, mul_b, mul_res, coef, acc_sat;
  logic [2*DATA_W-1:0] prod_full;
  logic [DATA_W:0]     sum;
  logic                last_k;

  always_comb begin
    coef  = mode_q ? coef_cos[k_q] : coef_sin[k_q];
    mul_a = term_q;
    mul_b = x2_q;
    case (state_q)
      StSquare: begin
        mul_a = x_q;
        mul_b = x_q;
      end
      StMulC:  mul_b = coef;
      default: ;
    endcase
    // Sign-extended operands give the exact signed product in the low 2*DATA_W bits
    prod_full = {{DATA_W{mul_a[DATA_W-1]}}, mul_a} * {{DATA_W{mul_b[DATA_W-1]}}, mul_b};
    mul_res   = DATA_W'($signed(prod_full) >>> FRAC_W);
  end

  always_comb begin
    if (k_q[0]) begin
      sum = {acc_q[DATA_W-1], acc_q} + {term_q[DATA_W-1], term_q};
    end else begin
      sum = {acc_q[DATA_W-1], acc_q} - {term_q[DATA_W-1], term_q};
    end
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      acc_sat = sum[DATA_W] ? SatMin : SatMax;
    end else begin
      acc_sat = sum[DATA_W-1:0];
    end
    last_k = (k_q == 3'(N_TERMS - 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      x2_q    <= '0;
      term_q  <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            x_q     <= x_in;
            mode_q  <= mode;
            term_q  <= mode ? OneV : x_in;
            acc_q   <= mode ? OneV : x_in;
            k_q     <= '0;
            busy    <= 1'b1;
            state_q <= StSquare;
          end
        end
        StSquare: begin
          x2_q <= mul_res;
          if (N_TERMS == 1) begin
            result  <= acc_q;
            done    <= 1'b1;
            state_q <= StFinish;
          end else begin
            state_q <= StMulX2;
          end
        end
        StMulX2: begin
          term_q  <= mul_res;
          state_q <= StMulC;
        end
        StMulC: begin
          term_q  <= mul_res;
          state_q <= StAcc;
        end
        StAcc: begin
          acc_q <= acc_sat;
          k_q   <= k_q + 3'd1;
          if (last_k) begin
            result  <= acc_sat;
            done    <= 1'b1;
            state_q <= StFinish;
          end else begin
            state_q <= StMulX2;
          end
        end
        StFinish: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_taylor_trig_unit.sv
// Randomised and directed checks of taylor_trig_unit against an arithmetic Taylor-series model.
module tb_taylor_trig_unit;

  localparam int DW = 16;
  localparam int FW = 13;
  localparam int NT = 5;
  localparam int LAT = 1 + 3 * (NT - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] x_in = '0;
  logic          busy, done;
  logic [DW-1:0] result;

  int total = 0;
  int bad = 0;

  taylor_trig_unit #(
    .DATA_W (DW),
    .FRAC_W (FW),
    .N_TERMS(NT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .x_in  (x_in),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap16(input longint v);
    int r;
    r = int'(v & 64'hFFFF);
    if (r >= 32768) r -= 65536;
    return r;
  endfunction

  function automatic int pmul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return wrap16(p >>> FW);
  endfunction

  function automatic int ref_coef(input bit m, input int k);
    int d;
    d = m ? (2 * k + 1) * (2 * k + 2) : (2 * k + 2) * (2 * k + 3);
    return (2 * (1 << FW) + d) / (2 * d);
  endfunction

  // Truncated series: sin = x - x^3/3! + ..., cos = 1 - x^2/2! + ...
  function automatic int ref_trig(input bit m, input int x);
    int term, acc, x2;
    term = m ? (1 << FW) : x;
    acc  = term;
    x2   = pmul(x, x);
    for (int k = 0; k < NT - 1; k++) begin
      term = pmul(pmul(term, x2), ref_coef(m, k));
      acc  = (k % 2 == 1) ? acc + term : acc - term;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
    end
    return acc;
  endfunction

  function automatic int sres();
    return int'($signed(result));
  endfunction

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (done) lat = n;
    end
    check({tag, "_lat"}, lat, LAT);
  endtask

  task automatic run_op(input bit m, input int x, input bit exact, input string tag,
                        output int r);
    int lat;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    x_in  = 16'(x);
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 1'($urandom);
    x_in  = 16'($urandom);
    check({tag, "_busy"}, int'(busy), 1);
    wait_done(tag, lat);
    r = sres();
    if (exact) check({tag, "_res"}, r, ref_trig(m, x));
    else check({tag, "_nox"}, int'($isunknown(result)), 0);
    @(posedge clk);
    #1;
    check({tag, "_donelo"}, int'(done), 0);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int r, lat, x, quiet;
    bit m;

    // reset then idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_res", sres(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy || done || result != 0) quiet++;
    end
    check("idle_quiet", quiet, 0);

    // directed test-plan points, exact model plus tolerance against the ideal value
    run_op(0, 0, 1, "sin0", r);
    check("sin0_val", r, 0);
    run_op(1, 0, 1, "cos0", r);
    check("cos0_val", r, 8192);
    run_op(0, 8192, 1, "sin1", r);
    check("sin1_tol", int'(r >= 6889 && r <= 6897), 1);
    run_op(1, 8192, 1, "cos1", r);
    check("cos1_tol", int'(r >= 4422 && r <= 4430), 1);
    run_op(0, -8192, 1, "sinm1", r);
    check("sinm1_tol", int'(r >= -6897 && r <= -6889), 1);
    run_op(0, 12868, 1, "sinpi2", r);
    check("sinpi2_tol", int'(r >= 8188 && r <= 8196 && r != 32767), 1);
    run_op(1, 12868, 1, "cospi2", r);
    check("cospi2_tol", int'(r >= -4 && r <= 4), 1);

    // start pulsed mid-operation is ignored
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    x_in  = 16'd8192;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    mode  = 1'b1;
    x_in  = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int n = 6; n <= 40 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (done) lat = n;
    end
    check("ign_lat", lat, LAT);
    check("ign_res", sres(), ref_trig(0, 8192));
    quiet = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) quiet++;
    end
    check("ign_single_done", quiet, 0);

    // reset mid-operation aborts without a done
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    x_in  = 16'd4000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_res", sres(), 0);
    quiet = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done || busy) quiet++;
    end
    check("abort_quiet", quiet, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 5000, 1, "post_rst", r);

    // back-to-back: start held high through FINISH launches the next op
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    x_in  = 16'd8192;
    @(posedge clk);
    #1;
    mode = 1'b1;
    x_in = 16'hE000;
    wait_done("b2b_a", lat);
    check("b2b_a_res", sres(), ref_trig(0, 8192));
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_b_busy", int'(busy), 1);
    wait_done("b2b_b", lat);
    check("b2b_b_res", sres(), ref_trig(1, -8192));
    repeat (2) @(posedge clk);

    // randomised legal operands
    for (int i = 0; i < 30; i++) begin
      x = int'($urandom_range(25736)) - 12868;
      m = 1'($urandom);
      run_op(m, x, 1, "rand", r);
    end

    // out-of-range operands: completion and no X only
    for (int i = 0; i < 4; i++) begin
      x = (i % 2 == 0) ? int'($urandom_range(32767, 20000)) : -int'($urandom_range(32768, 20000));
      run_op(1'(i / 2), x, 0, "oor", r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
